axi_sample_bridge: RTL
======================

// Module: axi_sample_bridge
// PURPOSE
//  AXI4 slave bridge between the host and the FFT sample RAM. Successor to the single-burst FFT bridge:
//  parametrised widths, full VALID/READY handshakes, FIXED/INCR/WRAP bursts, correct LEN+1 beat count,
//  BRESP/RRESP error reporting, and full-throughput reads against a 1-cycle-latency RAM.
//  Loads samples before the transform; returns results once i_CALC_END has been seen.
// PARAMETERS
//  SAMPLE_WIDTH  16  sample width written to RAM (low bits of WDATA)
//  DATA_WIDTH    32  AXI R/W data width and RAM read width
//  ADDR_WIDTH    12  AXI byte address width; RAM index width
//  ID_WIDTH      2   AWID/ARID/BID/RID width
// PORTS
//  i_clk               in   1             clock
//  i_rstn              in   1             async active-low reset
//  i_AWADDR/i_ARADDR   in   ADDR_WIDTH    burst start byte address
//  i_AWLEN/i_ARLEN     in   8             beats-1
//  i_AWSIZE/i_ARSIZE   in   3             log2 bytes/beat
//  i_AWBURST/i_ARBURST in   2             00 FIXED, 01 INCR, 10 WRAP
//  i_AWID/i_ARID       in   ID_WIDTH      transaction ID
//  i_AWVALID/i_ARVALID in 1; o_AWREADY/o_ARREADY out 1   address handshakes
//  i_WDATA in DATA_WIDTH; i_WSTRB in DATA_WIDTH/8; i_WLAST,i_WVALID in 1; o_WREADY out 1
//  o_BID out ID_WIDTH; o_BRESP out 2; o_BVALID out 1; i_BREADY in 1
//  o_RDATA out DATA_WIDTH; o_RID out ID_WIDTH; o_RRESP out 2; o_RLAST,o_RVALID out 1; i_RREADY in 1
//  i_DATA_FROM_RAM in DATA_WIDTH; i_CALC_END in 1 (pulse); i_SAMPLES_NUMBER in ADDR_WIDTH
//  o_SAMPLE_ram out SAMPLE_WIDTH; o_SAMPLE_INDEX_ram out ADDR_WIDTH; o_WRITE_ram,o_READ_ram out 1
//  o_DATA_LOADED out 1 (1-cycle pulse)
// BEHAVIOUR
//  Reset: every output 0, state IDLE, calc_done 0; mid-burst reset abandons burst, prior RAM writes stand.
//  States: IDLE -> WR_DATA -> WR_RESP -> IDLE; IDLE -> RD_DATA -> IDLE.
//  IDLE: o_AWREADY=1, o_ARREADY=calc_done. AW and AR valid together -> AW wins. Addr/len/size/burst/ID
//   latched on handshake; data phase starts next cycle. AW handshake clears calc_done; i_CALC_END sets it;
//   both in same cycle -> cleared.
//  Address gen: index = addr>>SIZE. FIXED: addr constant; INCR: addr += 1<<SIZE; WRAP: wraps inside
//   aligned window of (LEN+1)<<SIZE bytes; LEN not in {1,3,7,15} or BURST=11 -> INCR, error flagged.
//  WR_DATA: o_WREADY=1. Each W handshake same cycle: o_WRITE_ram=1, o_SAMPLE_ram=WDATA[SAMPLE_WIDTH-1:0].
//   Write suppressed + error flagged if WSTRB not all-ones or index >= i_SAMPLES_NUMBER.
//   Exactly LEN+1 beats; WLAST on wrong beat or missing on last -> error; leave after beat LEN+1.
//  WR_RESP: o_BVALID=1, o_BID=AWID, o_BRESP=OKAY(00) or SLVERR(10) if any error. On BREADY -> IDLE;
//   o_DATA_LOADED pulses that cycle iff OKAY.
//  RD_DATA: read issued (o_READ_ram=1, index) when beats remain and (!o_RVALID || i_RREADY); RAM data
//   captured next cycle into o_RDATA register -> 1 beat/clk at RREADY=1, zero loss under backpressure.
//   o_RID=ARID; o_RLAST on beat LEN+1; out-of-range index -> RDATA 0, RRESP SLVERR. Last handshake -> IDLE.
//  Outputs in RD/WR_RESP hold stable while VALID && !READY.
// STRUCTURE
//  axi_bridge_pkg: state enum, BURST_FIXED/INCR/WRAP, RESP_OKAY/SLVERR.
//  Sub-module axi_burst_addr_gen: latch start/len/size/burst, step on beat, emits index and last flag;
//  one instance shared by read and write paths.
// TESTING
//  INCR AW addr 0,LEN 7,SIZE 1, 8 W beats WLAST on 8th -> RAM idx 0..7 written, BRESP 00, DATA_LOADED pulse.
//  AR before i_CALC_END -> ARREADY 0; pulse CALC_END, AR LEN 3 -> 4 R beats, RLAST on 4th, RID=ARID.
//  Read LEN 15 with RREADY toggling 1,0,0,1 -> no dropped/duplicated beats, RDATA held while stalled.
//  WRAP AW addr 0x0C,LEN 3,SIZE 2 -> idx 3,0,1,2; FIXED LEN 3 addr 8,SIZE 1 -> idx 4 four times.
//  WLAST on beat 3 of LEN 3, or WSTRB 0x3 on 32-bit, or idx >= SAMPLES_NUMBER -> BRESP 10, no pulse.
//  i_rstn low mid write burst -> outputs 0, IDLE; next AW accepted normally.

Source files
------------

// File: rtl/axi_bridge_pkg.sv
// Shared types and encodings for the AXI4 sample-RAM bridge.
package axi_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_DATA = 2'd1,
    ST_WR_RESP = 2'd2,
    ST_RD_DATA = 2'd3
  } state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Response and last flag travelling alongside each read beat.
  typedef struct packed {
    logic [1:0] resp;
    logic       last;
  } rd_meta_t;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Burst address generator: latches a burst descriptor, steps one beat at a time,
// and presents the RAM index of the current beat plus a last-beat flag.
module axi_burst_addr_gen
  import axi_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [7:0]            len_i,
  input  logic [2:0]            size_i,
  input  logic [1:0]            burst_i,
  output logic [ADDR_WIDTH-1:0] index_o,
  output logic                  last_o,
  output logic                  cfg_err_o
);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, beat_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q, load_burst;
  logic                  cfg_err_q, load_err;
  logic [ADDR_WIDTH-1:0] step_bytes, wrap_mask, incr_addr;

  // Unsupported wrap lengths and the reserved encoding degrade to INCR with an error.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    load_burst = burst_i;
    load_err   = 1'b0;
    if (burst_i == 2'b11 || (burst_i == BURST_WRAP && !wrap_len_ok(len_i))) begin
      load_burst = BURST_INCR;
      load_err   = 1'b1;
    end
  end

  assign step_bytes = ADDR_WIDTH'(1) << size_q;
  assign wrap_mask  = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
  assign incr_addr  = addr_q + step_bytes;

  always_comb begin
    addr_d = incr_addr;
    case (burst_q)
      BURST_FIXED: addr_d = addr_q;
      BURST_WRAP:  addr_d = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     addr_d = incr_addr;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      size_q    <= '0;
      burst_q   <= BURST_INCR;
      cfg_err_q <= 1'b0;
    end else if (load_i) begin
      addr_q    <= addr_i;
      len_q     <= len_i;
      beat_q    <= '0;
      size_q    <= size_i;
      burst_q   <= load_burst;
      cfg_err_q <= load_err;
    end else if (step_i) begin
      addr_q <= addr_d;
      beat_q <= beat_q + 8'd1;
    end
  end

  assign index_o   = addr_q >> size_q;
  assign last_o    = (beat_q == len_q);
  assign cfg_err_o = cfg_err_q;

endmodule

// File: rtl/axi_sample_bridge.sv
// AXI4 slave bridge to the FFT sample RAM: burst writes load samples, burst reads
// return results once the transform has signalled completion.
module axi_sample_bridge
  import axi_bridge_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned ID_WIDTH     = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic [ADDR_WIDTH-1:0]   i_AWADDR,
  input  logic [7:0]              i_AWLEN,
  input  logic [2:0]              i_AWSIZE,
  input  logic [1:0]              i_AWBURST,
  input  logic [ID_WIDTH-1:0]     i_AWID,
  input  logic                    i_AWVALID,
  output logic                    o_AWREADY,
  input  logic [ADDR_WIDTH-1:0]   i_ARADDR,
  input  logic [7:0]              i_ARLEN,
  input  logic [2:0]              i_ARSIZE,
  input  logic [1:0]              i_ARBURST,
  input  logic [ID_WIDTH-1:0]     i_ARID,
  input  logic                    i_ARVALID,
  output logic                    o_ARREADY,
  input  logic [DATA_WIDTH-1:0]   i_WDATA,
  input  logic [DATA_WIDTH/8-1:0] i_WSTRB,
  input  logic                    i_WLAST,
  input  logic                    i_WVALID,
  output logic                    o_WREADY,
  output logic [ID_WIDTH-1:0]     o_BID,
  output logic [1:0]              o_BRESP,
  output logic                    o_BVALID,
  input  logic                    i_BREADY,
  output logic [DATA_WIDTH-1:0]   o_RDATA,
  output logic [ID_WIDTH-1:0]     o_RID,
  output logic [1:0]              o_RRESP,
  output logic                    o_RLAST,
  output logic                    o_RVALID,
  input  logic                    i_RREADY,
  input  logic [DATA_WIDTH-1:0]   i_DATA_FROM_RAM,
  input  logic                    i_CALC_END,
  input  logic [ADDR_WIDTH-1:0]   i_SAMPLES_NUMBER,
  output logic [SAMPLE_WIDTH-1:0] o_SAMPLE_ram,
  output logic [ADDR_WIDTH-1:0]   o_SAMPLE_INDEX_ram,
  output logic                    o_WRITE_ram,
  output logic                    o_READ_ram,
  output logic                    o_DATA_LOADED
);

  state_e                state_q, state_d;
  logic                  alive_q, calc_done_q, wr_err_q, rd_all_issued_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic                  pend_q, rvalid_q, skid_v_q;
  rd_meta_t              pend_meta_q, rmeta_q, skid_meta_q, issue_meta;
  logic [DATA_WIDTH-1:0] rdata_q, skid_data_q, pend_data;

  logic                  idle, aw_hs, ar_hs, w_hs, b_hs, rd_issue, r_hs, rd_done;
  logic                  in_range, strb_ok, beat_err;
  logic [ADDR_WIDTH-1:0] gen_index;
  logic                  gen_last, gen_cfg_err;
  logic                  unused_wdata_hi;

  assign unused_wdata_hi = ^i_WDATA[DATA_WIDTH-1:SAMPLE_WIDTH];

  // alive_q keeps the ready outputs low while reset is asserted.
  assign idle     = (state_q == ST_IDLE) && alive_q;
  assign aw_hs    = idle && i_AWVALID;
  assign ar_hs    = idle && !i_AWVALID && calc_done_q && i_ARVALID;
  assign w_hs     = (state_q == ST_WR_DATA) && i_WVALID;
  assign b_hs     = (state_q == ST_WR_RESP) && i_BREADY;
  assign rd_issue = (state_q == ST_RD_DATA) && !rd_all_issued_q && (!rvalid_q || i_RREADY);
  assign r_hs     = rvalid_q && i_RREADY;
  assign rd_done  = r_hs && rmeta_q.last;

  assign in_range = gen_index < i_SAMPLES_NUMBER;
  assign strb_ok  = &i_WSTRB;
  assign beat_err = !strb_ok || !in_range || (i_WLAST != gen_last) || gen_cfg_err;

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .clk      (i_clk),
    .rst_n    (i_rstn),
    .load_i   (aw_hs || ar_hs),
    .step_i   (w_hs || rd_issue),
    .addr_i   (aw_hs ? i_AWADDR  : i_ARADDR),
    .len_i    (aw_hs ? i_AWLEN   : i_ARLEN),
    .size_i   (aw_hs ? i_AWSIZE  : i_ARSIZE),
    .burst_i  (aw_hs ? i_AWBURST : i_ARBURST),
    .index_o  (gen_index),
    .last_o   (gen_last),
    .cfg_err_o(gen_cfg_err)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (aw_hs) state_d = ST_WR_DATA;
                  else if (ar_hs) state_d = ST_RD_DATA;
      ST_WR_DATA: if (w_hs && gen_last) state_d = ST_WR_RESP;
      ST_WR_RESP: if (i_BREADY) state_d = ST_IDLE;
      ST_RD_DATA: if (rd_done) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_AWREADY          = idle;
    o_ARREADY          = idle && calc_done_q;
    o_WREADY           = (state_q == ST_WR_DATA);
    o_WRITE_ram        = w_hs && strb_ok && in_range;
    o_SAMPLE_ram       = w_hs ? i_WDATA[SAMPLE_WIDTH-1:0] : '0;
    o_SAMPLE_INDEX_ram = (w_hs || rd_issue) ? gen_index : '0;
    o_READ_ram         = rd_issue && in_range;
    o_BVALID           = (state_q == ST_WR_RESP);
    o_BID              = o_BVALID ? id_q : '0;
    o_BRESP            = (o_BVALID && wr_err_q) ? RESP_SLVERR : RESP_OKAY;
    o_DATA_LOADED      = b_hs && !wr_err_q;
  end

  always_comb begin
    issue_meta.resp = (in_range && !gen_cfg_err) ? RESP_OKAY : RESP_SLVERR;
    issue_meta.last = gen_last;
  end

  assign pend_data = (pend_meta_q.resp == RESP_OKAY) ? i_DATA_FROM_RAM : '0;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      alive_q         <= 1'b0;
      calc_done_q     <= 1'b0;
      wr_err_q        <= 1'b0;
      rd_all_issued_q <= 1'b0;
      id_q            <= '0;
    end else begin
      alive_q <= 1'b1;
      if (aw_hs)           calc_done_q <= 1'b0;
      else if (i_CALC_END) calc_done_q <= 1'b1;
      if (aw_hs)                 wr_err_q <= 1'b0;
      else if (w_hs && beat_err) wr_err_q <= 1'b1;
      if (ar_hs)                     rd_all_issued_q <= 1'b0;
      else if (rd_issue && gen_last) rd_all_issued_q <= 1'b1;
      if (aw_hs)      id_q <= i_AWID;
      else if (ar_hs) id_q <= i_ARID;
    end
  end

  // Read data returns one cycle after issue; the skid slot catches it when the
  // output register is stalled, so issuing on (!RVALID || RREADY) never drops a beat.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      // NOTE: the data registers are reset too because they drive ports that must read 0 in reset.
      pend_q      <= 1'b0;
      pend_meta_q <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rmeta_q     <= '0;
      skid_v_q    <= 1'b0;
      skid_data_q <= '0;
      skid_meta_q <= '0;
    end else begin
      pend_q <= rd_issue;
      if (rd_issue) pend_meta_q <= issue_meta;
      if (!rvalid_q || i_RREADY) begin
        if (skid_v_q) begin
          rdata_q  <= skid_data_q;
          rmeta_q  <= skid_meta_q;
          rvalid_q <= 1'b1;
          skid_v_q <= 1'b0;
        end else if (pend_q) begin
          rdata_q  <= pend_data;
          rmeta_q  <= pend_meta_q;
          rvalid_q <= 1'b1;
        end else begin
          rvalid_q <= 1'b0;
        end
      end else if (pend_q) begin
        skid_data_q <= pend_data;
        skid_meta_q <= pend_meta_q;
        skid_v_q    <= 1'b1;
      end
    end
  end

  assign o_RVALID = rvalid_q;
  assign o_RDATA  = rdata_q;
  assign o_RID    = id_q;
  assign o_RRESP  = rvalid_q ? rmeta_q.resp : RESP_OKAY;
  assign o_RLAST  = rvalid_q && rmeta_q.last;

endmodule
